// File: rtl/cacheline_adapter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cacheline_adapter_pkg                                         |
// | Purpose  : Shared types and constants for the cacheline <-> burst memory |
// |            adapter: FSM state encoding and line/beat geometry.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cacheline_adapter_pkg;

    localparam int BEAT_W      = 64;
    localparam int BEATS       = 4;
    localparam int LINE_W      = BEAT_W * BEATS;
    localparam int LINE_OFFSET = 5;   // log2(LINE_W/8): byte offset bits inside a line

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } adapter_state_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cacheline_adapter                                             |
// | Purpose  : Bridges a 256-bit cacheline request port (dfp) to a 64-bit    |
// |            burst memory port (bmem). One line transaction at a time:     |
// |            reads issue one request and gather four tagged beats, writes  |
// |            stream four beats under bmem_ready flow control.              |
// | Ports    : clk, rst               - clock, synchronous active-high reset |
// |            dfp_addr/read/write    - line request from the cache          |
// |            dfp_wdata              - line to write                        |
// |            dfp_rdata, dfp_resp    - assembled read line, done pulse      |
// |            bmem_addr/read/write   - line-aligned request to memory       |
// |            bmem_wdata, bmem_ready - write beat, memory accept            |
// |            bmem_raddr/rdata/rvalid- returning read beat and its tag      |
// |            err                    - sticky protocol-error flag           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cacheline_adapter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        dfp_addr,
    input  logic                     dfp_read,
    input  logic                     dfp_write,
    input  logic [BEAT_W*BEATS-1:0]  dfp_wdata,
    output logic [BEAT_W*BEATS-1:0]  dfp_rdata,
    output logic                     dfp_resp,
    output logic [ADDR_W-1:0]        bmem_addr,
    output logic                     bmem_read,
    output logic                     bmem_write,
    output logic [BEAT_W-1:0]        bmem_wdata,
    input  logic                     bmem_ready,
    input  logic [ADDR_W-1:0]        bmem_raddr,
    input  logic [BEAT_W-1:0]        bmem_rdata,
    input  logic                     bmem_rvalid,
    output logic                     err
);

    import cacheline_adapter_pkg::*;

    localparam int c_line_w = BEAT_W * BEATS;
    localparam int c_cnt_w  = $clog2(BEATS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BEATS - 1);

    adapter_state_t        r_state;
    adapter_state_t        w_state_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_line_w-1:0]   r_line;     // write data, or read line under assembly
    logic [c_line_w-1:0]   r_rdata;    // last completed read line
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_err;

    logic                  w_last;
    logic                  w_hit;
    logic                  w_err_evt;
    logic [c_line_w-1:0]   w_line_fill;
    logic                  w_unused;

    // Offset bits inside a line are intentionally ignored.
    assign w_unused = &{1'b0, dfp_addr[LINE_OFFSET-1:0]};

    assign w_last = (r_cnt == c_last);
    assign w_hit  = (r_state == RD_WAIT) && bmem_rvalid && (bmem_raddr == r_addr);

    // Any beat not addressed to the read in progress is a protocol error,
    // including stragglers of a read abandoned by reset.
    assign w_err_evt = ((r_state == IDLE) && dfp_read && dfp_write) ||
                       (bmem_rvalid && !w_hit);

    // Line with the arriving beat merged in; also feeds dfp_rdata on the last
    // beat so the response line is valid in the same cycle as dfp_resp.
    always_comb begin
        w_line_fill = r_line;
        w_line_fill[r_cnt*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_wdata   = '0;
        dfp_resp     = 1'b0;
        case (r_state)
            IDLE: begin
                // Read has priority when both requests are raised.
                if (dfp_read) begin
                    w_state_next = RD_REQ;
                end else if (dfp_write) begin
                    w_state_next = WR;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (w_hit && w_last) begin
                    w_state_next = RESP;
                end
            end
            WR: begin
                bmem_write = 1'b1;
                bmem_wdata = r_line[r_cnt*BEAT_W +: BEAT_W];
                if (bmem_ready && w_last) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                dfp_resp     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_line  <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dfp_read || dfp_write) begin
                        r_addr <= {dfp_addr[ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
                    end
                    if (dfp_write && !dfp_read) begin
                        r_line <= dfp_wdata;
                    end
                end
                RD_WAIT: begin
                    if (w_hit) begin
                        r_line <= w_line_fill;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_rdata <= w_line_fill;
                        end
                    end
                end
                WR: begin
                    if (bmem_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_cnt <= '0;
                end
                default: begin
                end
            endcase
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bmem_addr = r_addr;
    assign dfp_rdata = r_rdata;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cacheline_adapter                                          |
// | Purpose  : Self-checking bench for cacheline_adapter. The bench plays    |
// |            both the cache and the burst memory; expected lines, beats,   |
// |            latencies and the error flag come from a transaction-level    |
// |            model kept here.                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cacheline_adapter;

    logic          clk;
    logic          rst;
    logic [31:0]   dfp_addr;
    logic          dfp_read;
    logic          dfp_write;
    logic [255:0]  dfp_wdata;
    logic [255:0]  dfp_rdata;
    logic          dfp_resp;
    logic [31:0]   bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [63:0]   bmem_wdata;
    logic          bmem_ready;
    logic [31:0]   bmem_raddr;
    logic [63:0]   bmem_rdata;
    logic          bmem_rvalid;
    logic          err;

    int            n_checks;
    int            n_fail;

    // Transaction-level model state
    bit            exp_err;
    logic [255:0]  last_rline;

    cacheline_adapter #(
        .ADDR_W (32),
        .BEAT_W (64),
        .BEATS  (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bmem_read"},  bmem_read,  0);
        chk({tag, "_bmem_write"}, bmem_write, 0);
        chk({tag, "_bmem_addr"},  bmem_addr,  0);
        chk({tag, "_bmem_wdata"}, bmem_wdata, 0);
        chk({tag, "_dfp_resp"},   dfp_resp,   0);
        chk({tag, "_dfp_rdata"},  dfp_rdata,  0);
        chk({tag, "_err"},        err,        0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dfp_read = 1'b0;  dfp_write = 1'b0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        exp_err = 1'b0;
        last_rline = '0;
    endtask

    // Read one line. Beat k carries line[64k+:64]. gaps holds per-beat idle
    // cycles (8 bits each) when rnd=0; rnd=1 randomises gaps and bmem_ready.
    // A rogue (mismatched-tag) beat is injected before beat rogue_beat.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input bit both,
                           input bit rnd, input logic [31:0] gaps, input int rogue_beat,
                           output int ncyc);
        logic [31:0] al;
        int          cyc;
        bit          rdy;
        int          g;
        al  = {addr[31:5], 5'b0};
        cyc = 0;
        dfp_addr  = addr;
        dfp_read  = 1'b1;
        dfp_write = both;
        dfp_wdata = rand_line();
        if (both) exp_err = 1'b1;
        tick(); cyc++;
        do begin
            chk("rd_req_read",  bmem_read,  1);
            chk("rd_req_nowr",  bmem_write, 0);
            chk("rd_req_addr",  bmem_addr,  al);
            rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bmem_ready = rdy;
            tick(); cyc++;
        end while (!rdy);
        bmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g = rnd ? int'($urandom_range(0, 3)) : int'(gaps[8*k +: 8]);
            if (k == rogue_beat && g == 0) g = 1;
            for (int j = 0; j < g; j++) begin
                chk("rd_wait_idle", {bmem_read, bmem_write, dfp_resp}, 0);
                if (k == rogue_beat && j == 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = 32'hDEAD_0000;
                    bmem_rdata  = {$urandom, $urandom};
                    exp_err     = 1'b1;
                end
                tick(); cyc++;
                bmem_rvalid = 1'b0;
            end
            chk("rd_wait_idle", {bmem_read, bmem_write, dfp_resp}, 0);
            bmem_rvalid = 1'b1;
            bmem_raddr  = al;
            bmem_rdata  = line[64*k +: 64];
            tick(); cyc++;
            bmem_rvalid = 1'b0;
        end
        chk("rd_resp", dfp_resp, 1);
        chk("rd_line", dfp_rdata, line);
        chk("rd_err",  err, exp_err);
        last_rline = line;
        ncyc = cyc;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        tick();
        chk("rd_resp_pulse", dfp_resp, 0);
        chk("rd_line_hold",  dfp_rdata, last_rline);
    endtask

    // Write one line. pat gives bmem_ready per write cycle when rnd=0.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input bit rnd,
                            input bit [15:0] pat, output int ncyc);
        logic [31:0] al;
        int          cyc;
        int          k;
        int          idx;
        bit          rdy;
        al  = {addr[31:5], 5'b0};
        cyc = 0;
        dfp_addr  = addr;
        dfp_write = 1'b1;
        dfp_read  = 1'b0;
        dfp_wdata = line;
        tick(); cyc++;
        k = 0;
        idx = 0;
        while (k < 4 && idx < 200) begin
            chk("wr_valid", bmem_write, 1);
            chk("wr_nord",  bmem_read,  0);
            chk("wr_addr",  bmem_addr,  al);
            chk("wr_beat",  bmem_wdata, line[64*k +: 64]);
            rdy = rnd ? ($urandom_range(0, 3) != 0) : ((idx < 16) ? pat[idx] : 1'b1);
            bmem_ready = rdy;
            tick(); cyc++; idx++;
            if (rdy) k++;
        end
        bmem_ready = 1'b0;
        chk("wr_resp",       dfp_resp,  1);
        chk("wr_rdata_keep", dfp_rdata, last_rline);
        chk("wr_err",        err,       exp_err);
        ncyc = cyc;
        dfp_write = 1'b0;
        tick();
        chk("wr_resp_pulse", dfp_resp,   0);
        chk("wr_done",       bmem_write, 0);
    endtask

    initial begin
        logic [255:0] line;
        logic [31:0]  a;
        int           n;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        exp_err = 1'b0;
        last_rline = '0;

        do_reset();

        // Directed read, ready=1, no gaps
        line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        do_read(32'h1000_0024, line, 1'b0, 1'b0, 32'h0, -1, n);
        chk("rd_latency", n, 6);

        // Directed write, words 0..7
        for (int i = 0; i < 8; i++) line[32*i +: 32] = i;
        do_write(32'h2000_0000, line, 1'b0, 16'hFFFF, n);
        chk("wr_latency", n, 5);

        // Same write with ready low on write cycles 2 and 3
        do_write(32'h2000_0000, line, 1'b0, 16'hFFF9, n);
        chk("wr_stall_latency", n, 7);

        // Randomised traffic, no protocol errors
        for (int t = 0; t < 40; t++) begin
            a = $urandom & 32'h7FFF_FFFF;
            line = rand_line();
            if ($urandom_range(0, 1) == 1)
                do_read(a, line, 1'b0, 1'b1, 32'h0, -1, n);
            else
                do_write(a, line, 1'b1, 16'h0, n);
        end

        // Gapped read: beats on cycles 5, 9, 10, 20, rogue beat before the last
        line = rand_line();
        do_read(32'h3000_0040, line, 1'b0, 1'b0, 32'h09_00_03_03, 3, n);
        chk("rd_gap_latency", n, 21);
        chk("rd_gap_err", err, 1);

        // Simultaneous read and write request
        do_reset();
        line = rand_line();
        do_read(32'h5000_0080, line, 1'b1, 1'b0, 32'h0, -1, n);
        chk("both_err", err, 1);

        // Reset in the middle of a read, then stray beats
        do_reset();
        line = rand_line();
        dfp_addr = 32'h4000_0048;
        dfp_read = 1'b1;
        tick();
        bmem_ready = 1'b1;
        tick();
        bmem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h4000_0040;
            bmem_rdata  = line[64*k +: 64];
            tick();
        end
        bmem_rvalid = 1'b0;
        dfp_read = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        last_rline = '0;
        for (int k = 2; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h4000_0040;
            bmem_rdata  = line[64*k +: 64];
            tick();
            chk("midrst_noresp", dfp_resp, 0);
        end
        bmem_rvalid = 1'b0;
        exp_err = 1'b1;
        tick();
        chk("midrst_err",    err,       exp_err);
        chk("midrst_noresp", dfp_resp,  0);
        chk("midrst_rdata",  dfp_rdata, last_rline);
        chk("midrst_idle",   {bmem_read, bmem_write}, 0);

        // Adapter still works after recovery
        line = rand_line();
        do_read(32'h6000_0000, line, 1'b0, 1'b1, 32'h0, -1, n);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
